// File: rtl/dino_pkg.sv
// Shared types and geometry helper for the Dino Run obstacle engine.
package dino_pkg;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_RUN  = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    localparam int SCREEN_W = 1280;

    // Boxes are left/top + width/height; callers zero-extend so sums never wrap.
    function automatic logic box_overlap(input logic [16:0] ax, input logic [16:0] ay,
                                         input logic [16:0] aw, input logic [16:0] ah,
                                         input logic [16:0] bx, input logic [16:0] by,
                                         input logic [16:0] bw, input logic [16:0] bh);
        return (ax < bx + bw) && (ax + aw > bx) && (ay < by + bh) && (ay + ah > by);
    endfunction

endpackage

// File: rtl/dino_lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 16,14,13,11) used to jitter respawn gaps.
module dino_lfsr16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = {1'b0, q_q[15:1]};
        if (q_q[0]) q_d = q_d ^ 16'hB400;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q_q <= seed;
        else          q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/dino_obstacle_engine.sv
// Obstacle motion, respawn, scoring, speed ramp and collision for Dino Run.
// Motion steps on frame_tick; collision is checked every cycle while running.
module dino_obstacle_engine
    import dino_pkg::*;
#(
    parameter int          NUM_OBS        = 4,
    parameter int          XW             = 11,
    parameter int          SPAWN_X        = 1280,
    parameter int          MIN_GAP        = 200,
    parameter int          SPEED_INIT     = 1,
    parameter int          SPEED_MAX      = 8,
    parameter int          PASS_PER_LEVEL = 12,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    input  logic                  start,
    input  logic [XW-1:0]         dino_x,
    input  logic [XW-1:0]         dino_y,
    input  logic [5:0]            dino_w,
    input  logic [5:0]            dino_h,
    input  logic [NUM_OBS*XW-1:0] obs_y_cfg,
    input  logic [NUM_OBS*8-1:0]  obs_w_cfg,
    input  logic [NUM_OBS*6-1:0]  obs_h_cfg,
    output logic [NUM_OBS*XW-1:0] obs_x,
    output logic [NUM_OBS-1:0]    obs_active,
    output logic [1:0]            game_state,
    output logic [NUM_OBS-1:0]    hit_mask,
    output logic [3:0]            speed,
    output logic [15:0]           score
);

    localparam int IW = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
    localparam int CW = $clog2(NUM_OBS + 1);
    localparam int PW = $clog2(PASS_PER_LEVEL + NUM_OBS + 1);

    if (SPAWN_X + (NUM_OBS - 1) * MIN_GAP >= (1 << XW) || XW > 16 || LFSR_SEED == 16'h0
        || NUM_OBS < 1 || NUM_OBS > 8) begin : g_cfg_err
        $error("dino_obstacle_engine: illegal parameter set");
    end

    function automatic logic [NUM_OBS-1:0][XW-1:0] reset_x();
        logic [NUM_OBS-1:0][XW-1:0] r;
        for (int i = 0; i < NUM_OBS; i++) r[i] = XW'(SPAWN_X + i * MIN_GAP);
        return r;
    endfunction

    localparam logic [NUM_OBS-1:0][XW-1:0] X_RST = reset_x();

    game_state_t                gs_q, gs_d;
    logic [NUM_OBS-1:0][XW-1:0] x_q, x_d, x_mv;
    logic [NUM_OBS-1:0]         act_q, act_d, hit_q, hit_d;
    logic [NUM_OBS-1:0]         ovl, pass, gap_blk;
    logic [3:0]                 speed_q, speed_d;
    logic [15:0]                score_q, score_d;
    logic [PW-1:0]              pcnt_q, pcnt_d, pcnt_sum;
    logic [16:0]                score_sum;
    logic                       start_q, start_rise;
    logic [15:0]                lfsr;
    logic                       lfsr_unused;
    logic [31:0]                gap_need;
    logic [CW-1:0]              npass;
    logic [IW-1:0]              spawn_idx;
    logic                       spawn_vld, spawn_ok;

    dino_lfsr16 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .q       (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:7];
    assign start_rise  = start & ~start_q;
    assign gap_need    = 32'(MIN_GAP) + 32'(lfsr[6:0]);

    for (genvar i = 0; i < NUM_OBS; i++) begin : g_ch
        logic [XW-1:0] oy;
        logic [7:0]    ow;
        logic [5:0]    oh;
        assign oy = obs_y_cfg[i*XW +: XW];
        assign ow = obs_w_cfg[i*8 +: 8];
        assign oh = obs_h_cfg[i*6 +: 6];
        assign ovl[i] = act_q[i] && box_overlap(17'(dino_x), 17'(dino_y), 17'(dino_w), 17'(dino_h),
                                                17'(x_q[i]), 17'(oy), 17'(ow), 17'(oh));
        assign pass[i]    = act_q[i] && (x_q[i] <= XW'(speed_q));
        assign x_mv[i]    = (act_q[i] && !pass[i]) ? x_q[i] - XW'(speed_q) : x_q[i];
        // Any active channel still too close to the right edge blocks a respawn.
        assign gap_blk[i] = act_q[i] && (32'(x_q[i]) + gap_need > 32'(SPAWN_X));
    end

    // Descending scan so the lowest inactive channel wins the respawn slot.
    always_comb begin
        npass     = '0;
        spawn_vld = 1'b0;
        spawn_idx = '0;
        for (int i = NUM_OBS - 1; i >= 0; i--) begin
            npass = npass + CW'(pass[i]);
            if (!act_q[i]) begin
                spawn_vld = 1'b1;
                spawn_idx = IW'(i);
            end
        end
        spawn_ok = spawn_vld && !(|gap_blk);
    end

    assign score_sum = {1'b0, score_q} + 17'(npass);
    assign pcnt_sum  = pcnt_q + PW'(npass);

    always_comb begin
        gs_d    = gs_q;
        x_d     = x_q;
        act_d   = act_q;
        hit_d   = hit_q;
        speed_d = speed_q;
        score_d = score_q;
        pcnt_d  = pcnt_q;
        case (gs_q)
            GS_RUN: begin
                if (|ovl) begin
                    gs_d  = GS_OVER;
                    hit_d = ovl;
                end else if (frame_tick) begin
                    x_d   = x_mv;
                    act_d = act_q & ~pass;
                    if (spawn_ok) begin
                        x_d[spawn_idx]   = XW'(SPAWN_X);
                        act_d[spawn_idx] = 1'b1;
                    end
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (pcnt_sum >= PW'(PASS_PER_LEVEL)) begin
                        pcnt_d  = pcnt_sum - PW'(PASS_PER_LEVEL);
                        speed_d = (speed_q >= 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed_q + 4'd1;
                    end else begin
                        pcnt_d = pcnt_sum;
                    end
                end
            end
            default: begin
                if (start_rise) begin
                    gs_d    = GS_RUN;
                    x_d     = X_RST;
                    act_d   = '1;
                    hit_d   = '0;
                    speed_d = 4'(SPEED_INIT);
                    score_d = '0;
                    pcnt_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gs_q    <= GS_IDLE;
            x_q     <= X_RST;
            act_q   <= '1;
            hit_q   <= '0;
            speed_q <= 4'(SPEED_INIT);
            score_q <= '0;
            pcnt_q  <= '0;
            start_q <= 1'b0;
        end else begin
            gs_q    <= gs_d;
            x_q     <= x_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            speed_q <= speed_d;
            score_q <= score_d;
            pcnt_q  <= pcnt_d;
            start_q <= start;
        end
    end

    assign obs_x      = x_q;
    assign obs_active = act_q;
    assign game_state = gs_q;
    assign hit_mask   = hit_q;
    assign speed      = speed_q;
    assign score      = score_q;

endmodule
